multi_mem_arbiter: RTL and testbench

- Shares the single-port multi_memory_core between two masters.
  - Port 0: the multi-cycle CPU's IorD-selected access.
  - Port 1: a debug/loader master that reads or writes memory while the board runs.
- Grants one access per grant cycle, round-robin.
- Supports an optional lock so a master can do back-to-back accesses, with bounded hold.
- Sits between the CPU/loader and memory_core in the top level.
- Read data is registered, and ack is a single-cycle pulse.

---
 rtl/multi_mem_pkg.sv | 23 ++
 rtl/multi_rr_pick.sv | 25 ++
 rtl/multi_mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_multi_mem_arbiter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/multi_mem_pkg.sv
// Shared encodings for the two-master memory arbiter.
package multi_mem_pkg;

    // State codes double as the owner LED code, so owner is the state itself.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10
    } state_e;

    localparam int P0 = 0;
    localparam int P1 = 1;

    localparam logic [1:0] OWNER_IDLE = 2'b00;
    localparam logic [1:0] OWNER_P0   = 2'b01;
    localparam logic [1:0] OWNER_P1   = 2'b10;

    // Map a port index to the state that serves it.
    function automatic state_e own_state(input logic port);
        return port ? ST_OWN1 : ST_OWN0;
    endfunction

endpackage

// File: rtl/multi_rr_pick.sv
// Two-way round-robin picker with an optional lock that restricts the grant
// to a single port.
module multi_rr_pick (
    input  logic [1:0] ereq,
    input  logic       pref,
    input  logic       lock_valid,
    input  logic       lock_port,
    output logic [1:0] grant
);

    // One-hot grant: lock owner only, else the preferred port on a tie.
    always_comb begin
        grant = 2'b00;
        if (lock_valid) begin
            if (lock_port) grant[1] = ereq[1];
            else           grant[0] = ereq[0];
        end else if (ereq == 2'b11) begin
            if (pref) grant = 2'b10;
            else      grant = 2'b01;
        end else begin
            grant = ereq;
        end
    end

endmodule

// File: rtl/multi_mem_arbiter.sv
// Shares the single-port memory core between the CPU (port 0) and a
// debug/loader master (port 1), one access per grant, round-robin, with a
// bounded lock for back-to-back accesses.
module multi_mem_arbiter
    import multi_mem_pkg::*;
#(
    parameter int AW       = 10,
    parameter int DW       = 32,
    parameter int MAX_HOLD = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_lock,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_lock,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] mem_a,
    output logic          mem_we,
    output logic [DW-1:0] mem_d,
    input  logic [DW-1:0] mem_spo,
    output logic [1:0]    owner
);

    localparam int                HOLD_W   = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT = HOLD_W'(MAX_HOLD);

    // Per-port views indexed by P0/P1.
    logic [1:0]         req, lock, we, ereq;
    logic [1:0][AW-1:0] addr;
    logic [1:0][DW-1:0] wdata;

    assign req   = {m1_req, m0_req};
    assign lock  = {m1_lock, m0_lock};
    assign we    = {m1_we, m0_we};
    assign addr  = {m1_addr, m0_addr};
    assign wdata = {m1_wdata, m0_wdata};

    state_e             state_q, state_d;
    logic               pref_q, pref_d;
    logic               lock_vld_q, lock_vld_d;
    logic               lock_port_q, lock_port_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [1:0]         ack_q, ack_d;
    logic [1:0][DW-1:0] rdata_q, rdata_d;

    logic       cur;
    logic       lock_live;
    logic [1:0] grant;

    // A master's req in its own ack cycle is the tail of the finished access.
    assign ereq = req & ~ack_q;
    assign cur  = (state_q == ST_OWN1);

    // A pending lock survives the owner's ack cycle as long as it keeps req
    // high; dropping req lapses it and normal arbitration takes over at once.
    assign lock_live = lock_vld_q & req[lock_port_q];

    multi_rr_pick u_pick (
        .ereq       (ereq),
        .pref       (pref_q),
        .lock_valid (lock_live),
        .lock_port  (lock_port_q),
        .grant      (grant)
    );

    // Next-state, lock/hold bookkeeping and completion capture.
    always_comb begin
        state_d     = state_q;
        pref_d      = pref_q;
        lock_vld_d  = lock_vld_q;
        lock_port_d = lock_port_q;
        hold_d      = hold_q;
        ack_d       = 2'b00;
        rdata_d     = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (lock_vld_q && !lock_live) begin
                    lock_vld_d = 1'b0;
                    hold_d     = '0;
                end
                if (grant[P0] || grant[P1]) begin
                    state_d    = own_state(grant[P1]);
                    lock_vld_d = 1'b0;
                end
            end
            ST_OWN0, ST_OWN1: begin
                state_d    = ST_IDLE;
                pref_d     = ~cur;
                ack_d[cur] = 1'b1;
                if (!we[cur]) rdata_d[cur] = mem_spo;
                // Hold limit only matters while the other port is waiting.
                if (lock[cur] && (!ereq[~cur] || hold_q < HOLD_LIM)) begin
                    lock_vld_d  = 1'b1;
                    lock_port_d = cur;
                    if (hold_q != HOLD_SAT) hold_d = hold_q + HOLD_W'(1);
                end else begin
                    lock_vld_d = 1'b0;
                    hold_d     = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset drops ownership so mem_we falls immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            pref_q      <= 1'b0;
            lock_vld_q  <= 1'b0;
            lock_port_q <= 1'b0;
            hold_q      <= '0;
            ack_q       <= 2'b00;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            pref_q      <= pref_d;
            lock_vld_q  <= lock_vld_d;
            lock_port_q <= lock_port_d;
            hold_q      <= hold_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
        end
    end

    // Memory bus follows the current owner; parked at zero while idle.
    always_comb begin
        mem_a  = '0;
        mem_we = 1'b0;
        mem_d  = '0;
        if (state_q != ST_IDLE) begin
            mem_a  = addr[cur];
            mem_we = we[cur];
            mem_d  = wdata[cur];
        end
    end

    assign m0_ack   = ack_q[P0];
    assign m1_ack   = ack_q[P1];
    assign m0_rdata = rdata_q[P0];
    assign m1_rdata = rdata_q[P1];
    assign owner    = state_q;

endmodule

// File: tb/tb_multi_mem_arbiter.sv
// Directed bench for multi_mem_arbiter with a behavioural memory core.
module tb_multi_mem_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int MH = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          m0_req = 0, m0_lock = 0, m0_we = 0;
    logic [AW-1:0] m0_addr = '0;
    logic [DW-1:0] m0_wdata = '0;
    logic          m1_req = 0, m1_lock = 0, m1_we = 0;
    logic [AW-1:0] m1_addr = '0;
    logic [DW-1:0] m1_wdata = '0;
    logic          m0_ack, m1_ack;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [AW-1:0] mem_a;
    logic          mem_we;
    logic [DW-1:0] mem_d, mem_spo;
    logic [1:0]    owner;

    multi_mem_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(MH)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .mem_a(mem_a), .mem_we(mem_we), .mem_d(mem_d), .mem_spo(mem_spo),
        .owner(owner)
    );

    always #5 clk = ~clk;

    // Memory core model: async read, write on rising edge, plus a preload port.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          ld_en = 1'b0;
    logic [AW-1:0] ld_a = '0;
    logic [DW-1:0] ld_d = '0;
    always @(posedge clk) begin
        if (ld_en)       mem[ld_a]  <= ld_d;
        else if (mem_we) mem[mem_a] <= mem_d;
    end
    assign mem_spo = mem[mem_a];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [1:0] g [0:7];
    int         gi, n0, n1;
    logic [3:0] e;

    initial begin
        // Preload under reset.
        ld_en = 1; ld_a = 10'd5; ld_d = 32'h1234ABCD; cyc(1);
        ld_a = 10'd7; ld_d = 32'h00007777; cyc(1);
        ld_a = 10'd3; ld_d = 32'h0;        cyc(1);
        ld_a = 10'd9; ld_d = 32'h0;        cyc(1);
        ld_en = 0;

        chk("rst_owner", owner, 2'b00);
        chk("rst_ack", {m0_ack, m1_ack}, 2'b00);
        chk("rst_rdata0", m0_rdata, 32'h0);
        chk("rst_rdata1", m1_rdata, 32'h0);
        chk("rst_mem", {mem_we, mem_a, mem_d}, '0);
        rst = 1; cyc(1);

        // Both masters reading continuously: P0 first, then alternate.
        m0_addr = 10'd5; m1_addr = 10'd7; m0_req = 1; m1_req = 1;
        for (int k = 1; k <= 8; k++) begin
            cyc(1);
            e[3:2] = (k % 2 == 1) ? ((k % 4 == 1) ? 2'b01 : 2'b10) : 2'b00;
            e[1]   = (k % 4 == 2);
            e[0]   = (k % 4 == 0);
            chk($sformatf("alt%0d", k), {owner, m0_ack, m1_ack}, e);
            if (k == 2) chk("alt_rd0", m0_rdata, 32'h1234ABCD);
            if (k == 4) chk("alt_rd1", m1_rdata, 32'h00007777);
        end
        m0_req = 0; m1_req = 0; cyc(1);

        // Single port 0 read.
        m0_addr = 10'd5; m0_req = 1; cyc(1);
        chk("rd_own", {owner, mem_a, mem_we}, {2'b01, 10'd5, 1'b0});
        cyc(1);
        chk("rd_ack", {owner, m0_ack, m1_ack}, {2'b00, 1'b1, 1'b0});
        chk("rd_data", m0_rdata, 32'h1234ABCD);
        m0_req = 0; cyc(1);
        chk("rd_ack_pulse", {m0_ack, m1_ack}, 2'b00);

        // Port 1 write, then port 0 reads it back.
        m1_we = 1; m1_addr = 10'd3; m1_wdata = 32'hDEADBEEF; m1_req = 1;
        chk("wr_idle_we", mem_we, 1'b0);
        cyc(1);
        chk("wr_own", {owner, mem_we, mem_a, mem_d}, {2'b10, 1'b1, 10'd3, 32'hDEADBEEF});
        cyc(1);
        chk("wr_ack", {m1_ack, mem_we}, 2'b10);
        chk("wr_rdata_kept", m1_rdata, 32'h00007777);
        chk("wr_mem", mem[3], 32'hDEADBEEF);
        m1_req = 0; m1_we = 0;
        m0_addr = 10'd3; m0_req = 1; cyc(2);
        chk("rb_ack", {m0_ack, m1_ack}, 2'b10);
        chk("rb_data", m0_rdata, 32'hDEADBEEF);
        m0_req = 0; cyc(1);

        // Lock under contention: P1 (preferred), then 3 locked P0, then P1.
        m0_addr = 10'd5; m1_addr = 10'd7; m0_lock = 1; m0_req = 1; m1_req = 1;
        gi = 0;
        for (int k = 0; k < 12; k++) begin
            cyc(1);
            if (owner != 2'b00 && gi < 8) begin g[gi] = owner; gi++; end
        end
        chk("lk_g0", g[0], 2'b10);
        chk("lk_g1", g[1], 2'b01);
        chk("lk_g2", g[2], 2'b01);
        chk("lk_g3", g[3], 2'b01);
        chk("lk_g4", g[4], 2'b10);

        // Locked master alone holds indefinitely: one grant every 3 cycles.
        m1_req = 0;
        n0 = 0; n1 = 0;
        repeat (45) begin
            cyc(1);
            if (owner == 2'b01) n0++;
            if (owner == 2'b10) n1++;
        end
        chk("solo_p0", n0, 15);
        chk("solo_p1", n1, 0);
        m0_req = 0; m0_lock = 0; cyc(2);

        // Reset in the middle of a port 1 write.
        m1_we = 1; m1_addr = 10'd9; m1_wdata = 32'hCAFEF00D; m1_req = 1; cyc(1);
        chk("mid_own", {owner, mem_we}, {2'b10, 1'b1});
        rst = 0; #1;
        chk("mid_rst_we", {owner, mem_we}, 3'b000);
        cyc(1);
        chk("mid_no_ack", {m0_ack, m1_ack}, 2'b00);
        chk("mid_mem", mem[9], 32'h0);
        rst = 1; cyc(1);
        chk("mid_retry_own", owner, 2'b10);
        cyc(1);
        chk("mid_retry_ack", m1_ack, 1'b1);
        chk("mid_retry_mem", mem[9], 32'hCAFEF00D);
        m1_req = 0; m1_we = 0; cyc(1);

        // req held through ack: no re-grant in the ack cycle.
        m0_addr = 10'd5; m0_req = 1; cyc(1);
        chk("hold_own", owner, 2'b01);
        cyc(1);
        chk("hold_ack", {owner, m0_ack, m1_ack}, 4'b0010);
        cyc(1);
        chk("hold_gap", {owner, m0_ack, m1_ack}, 4'b0000);
        cyc(1);
        chk("hold_regrant", owner, 2'b01);
        m0_req = 0; cyc(1);
        chk("hold_ack2", {m0_ack, m0_rdata}, {1'b1, 32'h1234ABCD});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
